nbit_serial_shift_right: RTL and testbench
==========================================

# nbit_serial_shift_right

Multi-cycle N-bit right shifter for the datapath. It performs logical and arithmetic right shifts one bit position per clock under a start/done handshake. It serves shift instructions where area matters more than latency, and complements the combinational left-shift-by-one used in branch-target generation. The result is registered and holds stable between operations.

## Interface
- N, default 32: operand/result width (N ≥ 2)
- SHW, default 5: shift-amount width; must satisfy 2^SHW ≥ N
- clk  input  1: clock, rising-edge
- rst  input  1: synchronous, active-high reset
- start  input  1: request; sampled only in IDLE or DONE
- x  input  N: operand, captured on an accepted start
- shamt  input  SHW: shift amount, captured on an accepted start
- arith  input  1: 1 = arithmetic (sign fill), 0 = logical (zero fill); captured on an accepted start
- busy  output  1: high while in SHIFT
- done  output  1: one-cycle pulse, y valid
- y  output  N: result register

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: shifts by one each cycle.
  - DONE: pulses done for one cycle.
- Internal registers: shift register sr[N-1:0], down-counter cnt[SHW-1:0], mode bit.
- IDLE, start=1: sr←x, cnt←shamt, mode←arith.
  - shamt=0: next state DONE.
  - Otherwise: next state SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge:
  - sr←{fill, sr[N-1:1]}, where fill = mode ? sr[N-1] : 0.
  - cnt←cnt−1.
  - When cnt=1 at the edge, next state is DONE.
- Entry into DONE loads y with the final sr value, which includes the last shift.
- DONE: done=1 for exactly one cycle.
  - start=1: accept as from IDLE (back-to-back operation).
  - Otherwise: next state IDLE.
- start while in SHIFT is ignored. The operation in flight continues unchanged.
- Shift-amount clamping: if shamt ≥ N (possible only when N is not a power of two), it is clamped to N−1 on capture.
- Arithmetic shift fills with the captured operand's MSB for every step. For a negative operand and shamt=N−1, the result is all ones.
- y changes only on entry into DONE. It holds its value through IDLE and SHIFT of the next operation.
- Reset values: state IDLE, busy=0, done=0, y=0, sr=0, cnt=0.
- Reset mid-operation aborts the operation. No done is produced and y returns to 0.
- Reset has priority over start in the same cycle.

## Timing
- Start is sampled at edge E0.
- done is high in the cycle after edge E0+shamt. That is, done asserts shamt+1 cycles after the cycle presenting start.
  - shamt=0: done in the cycle immediately after start; busy never asserts.
  - shamt=k>0: busy is high for k cycles, then done is high for 1 cycle, with busy=0 during done.
- Maximum throughput: one operation per shamt+1 cycles, achieved by asserting start during the DONE cycle.
- y is valid from the first done cycle until the next entry into DONE or reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: SHIFT_LEFT_EN.
- Defined:
  - Adds port `left  input  1`, captured on an accepted start.
  - left=1 shifts left per step: sr←{sr[N-2:0], 1'b0}. arith is ignored.
  - left=0 behaves exactly as the undefined build.
  - Latency is identical in both directions.
- Undefined:
  - The left port is absent.
  - Right shifts only.
  - No left-shift logic is synthesized.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, y=32'h0000_0000; no done pulse after release.
- Logical shift: x=32'h8000_00F0, shamt=4, arith=0 → busy for 4 cycles, done in cycle 5, y=32'h0800_000F.
- Arithmetic shift:
  - x=32'h8000_00F0, shamt=4, arith=1 → done in cycle 5, y=32'hF800_000F.
  - x=32'h8000_0000, shamt=31, arith=1 → y=32'hFFFF_FFFF.
- Zero shift and back-to-back:
  - x=32'hDEAD_BEEF, shamt=0 → done the next cycle, busy never high, y=32'hDEAD_BEEF.
  - Start again during done with x=32'h0000_0100, shamt=8, arith=0 → y=32'h0000_0001 after 9 cycles.
- Ignored start and abort:
  - start with new operands during SHIFT → ignored, original result delivered.
  - rst on the 2nd SHIFT cycle → no done, y=0; the next operation completes correctly.
- SHIFT_LEFT_EN build: x=32'h0000_0001, shamt=31, left=1 → done after 32 cycles, y=32'h8000_0000; with left=0 the right-shift cases above are unchanged.

Source files
------------

// File: rtl/nbit_serial_shift_right.sv
// ---------------------------------------------------------------------------
// nbit_serial_shift_right
//
// Multi-cycle N-bit shifter. It moves the operand one bit position per clock
// under a start/done handshake. Logical (zero fill) and arithmetic (sign fill)
// right shifts are supported. The result register y is updated only on entry
// into DONE and holds its value between operations.
//
// Optional feature macro: SHIFT_LEFT_EN
//   When defined, this adds the input 'left'. left=1 makes each step a logical
//   left shift and ignores 'arith'. Latency is the same in both directions.
//   When undefined, the port and all left-shift logic are absent.
//
// Parameters:
//   N    operand/result width (N >= 2)
//   SHW  shift-amount width (2**SHW >= N)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (takes priority over start)
//   start  request, sampled only in IDLE or DONE
//   x      operand, captured on an accepted start
//   shamt  shift amount, captured on an accepted start (clamped to N-1)
//   arith  1 = arithmetic right shift, 0 = logical; captured on accept
//   left   (SHIFT_LEFT_EN only) 1 = left shift; captured on accept
//   busy   high while shifting
//   done   one-cycle pulse; y is valid from this cycle on
//   y      result register
// ---------------------------------------------------------------------------
module nbit_serial_shift_right #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   x,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
`ifdef SHIFT_LEFT_EN
  input  logic           left,
`endif
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   y
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // The largest useful shift amount. A larger amount can only occur when N is
  // not a power of two.
  localparam logic [SHW-1:0] SH_MAX = SHW'(N - 1);

  state_t         state;
  logic [N-1:0]   sr;
  logic [SHW-1:0] cnt;
  logic           mode;
`ifdef SHIFT_LEFT_EN
  logic           left_mode;
`endif

  logic [SHW-1:0] shamt_clamped;
  logic [N-1:0]   sr_step;

  // The shift register after one more step. In arithmetic mode, replicating
  // sr's MSB keeps the captured operand's sign bit in place on every step, so
  // the fill always equals the original MSB.
  always_comb begin
    // NOTE: give every always_comb output a default first. A path that leaves
    // a signal unassigned would infer a latch.
    shamt_clamped = (shamt > SH_MAX) ? SH_MAX : shamt;
    sr_step       = sr >> 1;
    if (mode) begin
      sr_step = $signed(sr) >>> 1;
    end
`ifdef SHIFT_LEFT_EN
    if (left_mode) begin
      sr_step = sr << 1;
    end
`endif
  end

  // A single registered FSM. All outputs are flops, so no input reaches an
  // output combinationally.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      sr    <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
`ifdef SHIFT_LEFT_EN
      left_mode <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE. This allows
        // back-to-back operations.
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          if (start) begin
            sr   <= x;
            cnt  <= shamt_clamped;
            mode <= arith;
`ifdef SHIFT_LEFT_EN
            left_mode <= left;
`endif
            if (shamt_clamped == '0) begin
              // A zero shift goes straight to DONE and returns the operand.
              state <= S_DONE;
              done  <= 1'b1;
              y     <= x;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        // start is ignored here. The operation in flight runs to completion.
        S_SHIFT: begin
          sr  <= sr_step;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            // y captures the value after the final step, in the same edge
            // that performs that step.
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            y     <= sr_step;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serial_shift_right.sv
// ---------------------------------------------------------------------------
// tb_nbit_serial_shift_right
//
// Self-checking bench for nbit_serial_shift_right (N=32, SHW=5). It runs the
// directed cases (reset, logical/arithmetic shifts, zero shift, back-to-back,
// ignored start, mid-operation abort) and then a block of random operations.
// An arithmetic reference model supplies the expected values. busy, done and
// y are checked on every cycle of every operation. With SHIFT_LEFT_EN defined,
// the bench also drives and checks the left port.
// ---------------------------------------------------------------------------
module tb_nbit_serial_shift_right;

  localparam int N   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   x;
  logic [SHW-1:0] shamt;
  logic           arith;
`ifdef SHIFT_LEFT_EN
  logic           left;
`endif
  logic           busy;
  logic           done;
  logic [N-1:0]   y;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] y_model;

  nbit_serial_shift_right #(.N(N), .SHW(SHW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .shamt (shamt),
    .arith (arith),
`ifdef SHIFT_LEFT_EN
    .left  (left),
`endif
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result, computed from the shift rules as plain arithmetic: shift
  // by the clamped amount at once, then OR in sign bits for a negative
  // arithmetic operand.
  function automatic logic [N-1:0] model(input logic [N-1:0] ox, input logic [SHW-1:0] osh,
                                         input logic oar, input logic olf);
    int k;
    logic [N-1:0] r;
    k = (int'(osh) > N - 1) ? N - 1 : int'(osh);
    if (olf) return ox << k;
    r = ox >> k;
    if (oar && ox[N-1]) r = r | ~({N{1'b1}} >> k);
    return r;
  endfunction

  // start=0 for n cycles. Expect no activity and y held.
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", N'(busy), N'(0));
      check("idle_done", N'(done), N'(0));
      check("idle_y", y, y_model);
    end
  endtask

  // Enter at a negedge. Present one operation and follow it cycle by cycle
  // to the done cycle. Return at the done cycle's negedge with start=0, so the
  // caller can issue the next operation back-to-back. With noise set, start is
  // re-asserted with random operands during SHIFT.
  task automatic do_op(input logic [N-1:0] ox, input logic [SHW-1:0] osh, input logic oar,
                       input logic olf, input bit noise, input string tag);
    int k;
    logic [N-1:0] exp;
    k   = (int'(osh) > N - 1) ? N - 1 : int'(osh);
    exp = model(ox, osh, oar, olf);
    start = 1'b1;
    x     = ox;
    shamt = osh;
    arith = oar;
`ifdef SHIFT_LEFT_EN
    left  = olf;
`endif
    @(posedge clk);
    #1;
    // Scramble the operand inputs to show that only the captured copies count.
    start = 1'b0;
    x     = $urandom;
    shamt = SHW'($urandom);
    arith = 1'($urandom);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, N'(busy), N'(1));
      check({tag, "_nodone"}, N'(done), N'(0));
      check({tag, "_yhold"}, y, y_model);
      if (noise && i < k) begin
        start = 1'b1;
        x     = $urandom;
        shamt = SHW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_done"}, N'(done), N'(1));
    check({tag, "_busy_low"}, N'(busy), N'(0));
    check({tag, "_y"}, y, exp);
    y_model = exp;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    x     = 32'h1234_5678;
    shamt = 5'd3;
    arith = 1'b0;
`ifdef SHIFT_LEFT_EN
    left  = 1'b0;
`endif
    y_model = '0;

    // Reset held for two cycles with start=1: reset wins.
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", N'(busy), N'(0));
      check("rst_done", N'(done), N'(0));
      check("rst_y", y, 32'h0000_0000);
    end
    rst = 1'b0;
    idle(3);

    // Directed cases, also checked against literal results.
    do_op(32'h8000_00F0, 5'd4, 1'b0, 1'b0, 1'b0, "lsr4");
    check("lsr4_lit", y, 32'h0800_000F);
    idle(1);
    do_op(32'h8000_00F0, 5'd4, 1'b1, 1'b0, 1'b0, "asr4");
    check("asr4_lit", y, 32'hF800_000F);
    idle(2);
    do_op(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b0, "asr31");
    check("asr31_lit", y, 32'hFFFF_FFFF);
    idle(1);
    do_op(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, "zero");
    check("zero_lit", y, 32'hDEAD_BEEF);
    do_op(32'h0000_0100, 5'd8, 1'b0, 1'b0, 1'b0, "b2b");
    check("b2b_lit", y, 32'h0000_0001);
    idle(1);

    // start is re-asserted with new operands during SHIFT and must be ignored.
    do_op(32'hC3C3_0F0F, 5'd9, 1'b1, 1'b0, 1'b1, "ignore");
    check("ignore_lit", y, 32'hFFE1_E187);
    idle(2);

    // Assert reset on the second SHIFT cycle. Expect an abort and no done.
    start = 1'b1;
    x     = 32'h7654_3210;
    shamt = 5'd10;
    arith = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort_busy1", N'(busy), N'(1));
    @(negedge clk);
    check("abort_busy2", N'(busy), N'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", N'(busy), N'(0));
    check("abort_done", N'(done), N'(0));
    check("abort_y", y, 32'h0000_0000);
    y_model = '0;
    idle(12);
    do_op(32'h7654_3210, 5'd10, 1'b0, 1'b0, 1'b0, "after_abort");
    idle(1);

`ifdef SHIFT_LEFT_EN
    do_op(32'h0000_0001, 5'd31, 1'b0, 1'b1, 1'b0, "lsl31");
    check("lsl31_lit", y, 32'h8000_0000);
    idle(1);
    do_op(32'h8000_00F0, 5'd4, 1'b1, 1'b1, 1'b0, "lsl4_arith_ignored");
    check("lsl4_lit", y, 32'h0000_0F00);
    idle(1);
`endif

    // Random operations with random gaps (0 = back-to-back) and random noise.
    for (int n = 0; n < 40; n++) begin
      int gap;
      logic lf;
      gap = $urandom_range(0, 2);
      lf  = 1'b0;
`ifdef SHIFT_LEFT_EN
      lf  = 1'($urandom);
`endif
      if (gap > 0) idle(gap);
      do_op(N'($urandom), SHW'($urandom_range(0, 31)), 1'($urandom), lf,
            $urandom_range(0, 3) == 0, "rand");
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
